// File: rtl/sevenseg_scan_decoder_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
// Segment patterns are active low on seg[6:0]; anode codes are active low.
package sevenseg_scan_decoder_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] AN_D0   = 4'b1110;
   localparam logic [3:0] AN_D1   = 4'b1101;
   localparam logic [3:0] AN_D2   = 4'b1011;
   localparam logic [3:0] AN_D3   = 4'b0111;
   localparam logic [3:0] AN_NONE = 4'b1111;

   typedef struct packed {
      logic [3:0] bcd;
      logic       blank;
      logic       dp;
   } slot_t;

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational decode of an active-low 7-segment pattern into BCD.
// Unknown patterns report BCD 0 with is_err set; all-off reports is_blank.
module sevenseg_pattern_decode
   import sevenseg_scan_decoder_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] bcd,
   output logic       is_blank,
   output logic       is_err
);

   always_comb begin
      bcd      = 4'd0;
      is_blank = 1'b0;
      is_err   = 1'b0;
      case (seg)
         SEG_0:     bcd = 4'd0;
         SEG_1:     bcd = 4'd1;
         SEG_2:     bcd = 4'd2;
         SEG_3:     bcd = 4'd3;
         SEG_4:     bcd = 4'd4;
         SEG_5:     bcd = 4'd5;
         SEG_6:     bcd = 4'd6;
         SEG_7:     bcd = 4'd7;
         SEG_8:     bcd = 4'd8;
         SEG_9:     bcd = 4'd9;
         SEG_BLANK: is_blank = 1'b1;
         default:   is_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Rebuilds four BCD digits from a multiplexed seg/an display bus and flags errors.
// Optional scan-stall monitor enabled by defining STALL_DETECT_EN.
module sevenseg_scan_decoder
   import sevenseg_scan_decoder_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  seg,
   input  logic [3:0]  an,
   output logic [15:0] digits,
   output logic [3:0]  dp,
   output logic [3:0]  blank,
   output logic        frame_valid,
   output logic        pat_err,
   output logic        an_err,
   output logic        stall
);

   localparam int CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 2);

   logic [7:0]    seg_s1_q, seg_s2_q;
   logic [3:0]    an_s1_q, an_s2_q, an_q;
   logic [CW-1:0] stab_cnt_q, stab_cnt_d;
   slot_t         slot_q [4];
   slot_t         slot_d [4];
   logic [3:0]    seen_q, seen_d;
   logic [15:0]   digits_q, digits_d;
   logic [3:0]    dp_q, dp_d, blank_q, blank_d;
   logic          frame_valid_q, frame_valid_d;
   logic          pat_err_q, pat_err_d;
   logic          an_err_q, an_err_d;
   logic          cap_valid;
   logic [1:0]    cap_idx;
   logic          dwell_hit;
   logic [3:0]    dec_bcd;
   logic          dec_blank, dec_err;

   sevenseg_pattern_decode u_decode (
      .seg      (seg_s2_q[6:0]),
      .bcd      (dec_bcd),
      .is_blank (dec_blank),
      .is_err   (dec_err)
   );

   // The counter saturates, so the capture fires only on the step into saturation.
   assign dwell_hit = (an_s2_q == an_q) && (stab_cnt_q == CNT_PRE);

   always_comb begin
      stab_cnt_d = stab_cnt_q;
      if (an_s2_q != an_q) begin
         stab_cnt_d = '0;
      end else if (stab_cnt_q != CNT_MAX) begin
         stab_cnt_d = stab_cnt_q + CW'(1);
      end else begin
         stab_cnt_d = stab_cnt_q;
      end
   end

   always_comb begin
      cap_valid = 1'b0;
      cap_idx   = 2'd0;
      an_err_d  = 1'b0;
      if (dwell_hit) begin
         case (an_s2_q)
            AN_D0:   begin cap_valid = 1'b1; cap_idx = 2'd0; end
            AN_D1:   begin cap_valid = 1'b1; cap_idx = 2'd1; end
            AN_D2:   begin cap_valid = 1'b1; cap_idx = 2'd2; end
            AN_D3:   begin cap_valid = 1'b1; cap_idx = 2'd3; end
            AN_NONE: cap_valid = 1'b0;
            default: an_err_d = 1'b1;
         endcase
      end else begin
         cap_valid = 1'b0;
      end
   end

   // Frame latch copies the pre-capture slots, so a coincident capture joins the next frame.
   always_comb begin
      slot_d        = slot_q;
      seen_d        = seen_q;
      digits_d      = digits_q;
      dp_d          = dp_q;
      blank_d       = blank_q;
      frame_valid_d = (seen_q == 4'hF);
      pat_err_d     = pat_err_q | (cap_valid & dec_err);
      if (frame_valid_d) begin
         seen_d = 4'h0;
         for (int i = 0; i < 4; i++) begin
            digits_d[i*4 +: 4] = slot_q[i].bcd;
            dp_d[i]            = slot_q[i].dp;
            blank_d[i]         = slot_q[i].blank;
         end
      end else begin
         seen_d = seen_q;
      end
      if (cap_valid) begin
         slot_d[cap_idx]  = '{bcd: dec_bcd, blank: dec_blank, dp: ~seg_s2_q[7]};
         seen_d[cap_idx]  = 1'b1;
      end else begin
         slot_d[cap_idx]  = slot_q[cap_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1_q      <= 8'hFF;
         seg_s2_q      <= 8'hFF;
         an_s1_q       <= 4'hF;
         an_s2_q       <= 4'hF;
         an_q          <= 4'hF;
         stab_cnt_q    <= '0;
         for (int i = 0; i < 4; i++) slot_q[i] <= '0;
         seen_q        <= 4'h0;
         digits_q      <= 16'h0000;
         dp_q          <= 4'h0;
         blank_q       <= 4'hF;
         frame_valid_q <= 1'b0;
         pat_err_q     <= 1'b0;
         an_err_q      <= 1'b0;
      end else begin
         seg_s1_q      <= seg;
         seg_s2_q      <= seg_s1_q;
         an_s1_q       <= an;
         an_s2_q       <= an_s1_q;
         an_q          <= an_s2_q;
         stab_cnt_q    <= stab_cnt_d;
         slot_q        <= slot_d;
         seen_q        <= seen_d;
         digits_q      <= digits_d;
         dp_q          <= dp_d;
         blank_q       <= blank_d;
         frame_valid_q <= frame_valid_d;
         pat_err_q     <= pat_err_d;
         an_err_q      <= an_err_d;
      end
   end

   assign digits      = digits_q;
   assign dp          = dp_q;
   assign blank       = blank_q;
   assign frame_valid = frame_valid_q;
   assign pat_err     = pat_err_q;
   assign an_err      = an_err_q;

`ifdef STALL_DETECT_EN
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

   logic [IW-1:0] idle_q, idle_d;
   logic          stall_q, stall_d;

   always_comb begin
      idle_d = idle_q;
      if (cap_valid) begin
         idle_d = '0;
      end else if (idle_q != IDLE_MAX) begin
         idle_d = idle_q + IW'(1);
      end else begin
         idle_d = idle_q;
      end
      stall_d = (idle_d == IDLE_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_q  <= '0;
         stall_q <= 1'b0;
      end else begin
         idle_q  <= idle_d;
         stall_q <= stall_d;
      end
   end

   assign stall = stall_q;
`else
   logic unused_timeout_s;
   assign unused_timeout_s = ^TIMEOUT_CYCLES;
   assign stall = 1'b0;
`endif

endmodule
